// File: rtl/antirebotes_multicanal.sv
// antirebotes_multicanal: N-channel debouncer with press, release,
// hold and auto-repeat single-cycle event pulses.
module antirebotes_canal #(
  parameter int   CNT_BITS        = 16,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic INVERT          = 1'b0,
  parameter int   HOLD_BITS       = 26,
  parameter int   HOLD_CYCLES     = 25000000,
  parameter int   REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic repeat_o
);

  localparam logic [1:0] ST_REL = 2'd0;
  localparam logic [1:0] ST_PRS = 2'd1;
  localparam logic [1:0] ST_HLD = 2'd2;

  localparam logic [CNT_BITS-1:0] DB_LAST =
    CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_LAST =
    HOLD_BITS'(HOLD_CYCLES - 1);
  localparam bit REP_EN = (REPEAT_CYCLES != 0);
  localparam int REP_SAFE = REP_EN ? REPEAT_CYCLES : 1;
  localparam logic [HOLD_BITS-1:0] REP_LAST =
    HOLD_BITS'(REP_SAFE - 1);

  logic                 sync1_q, sync2_q;
  logic                 clean_q, clean_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 rise, fall;
  logic [1:0]           state_q, state_d;
  logic [HOLD_BITS-1:0] hcnt_q, hcnt_d;
  logic                 press_q, release_q;
  logic                 hold_q, hold_d;
  logic                 rep_q, rep_d;

  // Any sample that agrees with the accepted level restarts the count
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (sync2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      cnt_d   = '0;
      clean_d = sync2_q;
      rise    = sync2_q;
      fall    = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // A falling edge overrides any hold/repeat due the same cycle
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    hold_d  = 1'b0;
    rep_d   = 1'b0;
    if (fall) begin
      state_d = ST_REL;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_REL: begin
          if (rise) begin
            state_d = ST_PRS;
            hcnt_d  = '0;
          end
        end
        ST_PRS: begin
          if (hcnt_q == HOLD_LAST) begin
            hold_d  = 1'b1;
            state_d = ST_HLD;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + HOLD_BITS'(1);
          end
        end
        ST_HLD: begin
          if (!REP_EN) begin
            hcnt_d = '0;
          end else if (hcnt_q == REP_LAST) begin
            rep_d  = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + HOLD_BITS'(1);
          end
        end
        default: begin
          state_d = ST_REL;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      clean_q   <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_REL;
      hcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      sync1_q   <= button_i ^ INVERT;
      sync2_q   <= sync1_q;
      clean_q   <= clean_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      press_q   <= rise;
      release_q <= fall;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
    end
  end

  assign clean_o   = clean_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;
  assign repeat_o  = rep_q;

endmodule

module antirebotes_multicanal #(
  parameter int              N_CH            = 4,
  parameter int              CNT_BITS        = 16,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter logic [N_CH-1:0] INVERT_MASK     = '0,
  parameter int              HOLD_BITS       = 26,
  parameter int              HOLD_CYCLES     = 25000000,
  parameter int              REPEAT_CYCLES   = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] button_clean,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] hold_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    antirebotes_canal #(
      .CNT_BITS        (CNT_BITS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT_MASK[g]),
      .HOLD_BITS       (HOLD_BITS),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .button_i  (button_in[g]),
      .clean_o   (button_clean[g]),
      .press_o   (press_pulse[g]),
      .release_o (release_pulse[g]),
      .hold_o    (hold_pulse[g]),
      .repeat_o  (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_antirebotes_multicanal.sv
// tb_antirebotes_multicanal: directed vectors for the debouncer,
// one build with auto-repeat and one with repeat disabled.
module tb_antirebotes_multicanal;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bin = 2'b01;
  logic [1:0] ca, pa, ra, ha, qa;
  logic [1:0] cb, pb, rb, hb, qb;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  antirebotes_multicanal #(
    .N_CH(2), .CNT_BITS(16), .DEBOUNCE_CYCLES(4),
    .INVERT_MASK(2'b10), .HOLD_BITS(26),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .button_in(bin),
    .button_clean(ca), .press_pulse(pa),
    .release_pulse(ra), .hold_pulse(ha),
    .repeat_pulse(qa)
  );

  antirebotes_multicanal #(
    .N_CH(2), .CNT_BITS(16), .DEBOUNCE_CYCLES(4),
    .INVERT_MASK(2'b10), .HOLD_BITS(26),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .button_in(bin),
    .button_clean(cb), .press_pulse(pb),
    .release_pulse(rb), .hold_pulse(hb),
    .repeat_pulse(qb)
  );

  typedef struct {
    logic [1:0] b;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [9:0] oa();
    return {ca, pa, ra, ha, qa};
  endfunction

  function automatic logic [9:0] ob();
    return {cb, pb, rb, hb, qb};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] got,
                     input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, got, exp);
    end
  endtask

  task automatic v(input int n, input logic [1:0] b,
                   input logic [1:0] c, input logic [1:0] p,
                   input logic [1:0] r);
    vec_t e;
    e.b   = b;
    e.exp = {c, p, r, 4'b0000};
    repeat (n) tbl.push_back(e);
  endtask

  // ch0 press held, released after edge P+s; P is the press edge
  task automatic press_seq(input int s, input int hz,
                           input string nm);
    logic [9:0] ea, eb;
    logic c0, r0, h0, q0;
    bin[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      ea = (k == 6) ? 10'b01_01_00_00_00 : 10'b0;
      chk($sformatf("%s_a_pre%0d", nm, k), oa(), ea);
      chk($sformatf("%s_b_pre%0d", nm, k), ob(), ea);
    end
    for (int t = 1; t <= hz; t++) begin
      step();
      c0 = (t < s + 6);
      r0 = (t == s + 6);
      h0 = (t == 20) && c0;
      q0 = (t > 20) && ((t - 20) % 8 == 0) && c0;
      ea = {1'b0, c0, 2'b00, 1'b0, r0, 1'b0, h0, 1'b0, q0};
      eb = {1'b0, c0, 2'b00, 1'b0, r0, 1'b0, h0, 2'b00};
      chk($sformatf("%s_a_t%0d", nm, t), oa(), ea);
      chk($sformatf("%s_b_t%0d", nm, t), ob(), eb);
      if (t == s) bin[0] = 1'b0;
    end
  endtask

  initial begin
    // power-up press on both channels, releases, ch1 alone, ch0 alone
    v(5, 2'b01, 2'b00, 2'b00, 2'b00);
    v(1, 2'b01, 2'b11, 2'b11, 2'b00);
    v(5, 2'b10, 2'b11, 2'b00, 2'b00);
    v(1, 2'b10, 2'b00, 2'b00, 2'b11);
    v(1, 2'b10, 2'b00, 2'b00, 2'b00);
    v(5, 2'b00, 2'b00, 2'b00, 2'b00);
    v(1, 2'b00, 2'b10, 2'b10, 2'b00);
    v(1, 2'b00, 2'b10, 2'b00, 2'b00);
    v(5, 2'b10, 2'b10, 2'b00, 2'b00);
    v(1, 2'b10, 2'b00, 2'b00, 2'b10);
    v(1, 2'b10, 2'b00, 2'b00, 2'b00);
    v(5, 2'b11, 2'b00, 2'b00, 2'b00);
    v(1, 2'b11, 2'b01, 2'b01, 2'b00);
    v(5, 2'b10, 2'b01, 2'b00, 2'b00);
    v(1, 2'b10, 2'b00, 2'b00, 2'b01);
    v(1, 2'b10, 2'b00, 2'b00, 2'b00);
    // 3-cycle pulse rejected, 4-cycle pulse accepted
    v(3, 2'b11, 2'b00, 2'b00, 2'b00);
    v(6, 2'b10, 2'b00, 2'b00, 2'b00);
    v(4, 2'b11, 2'b00, 2'b00, 2'b00);
    v(1, 2'b10, 2'b00, 2'b00, 2'b00);
    v(1, 2'b10, 2'b01, 2'b01, 2'b00);
    v(3, 2'b10, 2'b01, 2'b00, 2'b00);
    v(1, 2'b10, 2'b00, 2'b00, 2'b01);
    v(1, 2'b10, 2'b00, 2'b00, 2'b00);

    repeat (3) begin
      step();
      chk("reset_a", oa(), 10'b0);
      chk("reset_b", ob(), 10'b0);
    end
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      bin = tbl[i].b;
      step();
      chk($sformatf("vec%0d_a", i), oa(), tbl[i].exp);
      chk($sformatf("vec%0d_b", i), ob(), tbl[i].exp);
    end

    for (int i = 0; i < 20; i++) begin
      bin = {1'b1, ((i >> 1) & 1) == 0};
      step();
      chk($sformatf("bounce%0d", i), oa(), 10'b0);
    end
    press_seq(52, 80, "hold");
    press_seq(14, 40, "relhold");
    press_seq(30, 50, "relrep");

    bin = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("mid_pre%0d", k), oa(),
          (k == 6) ? 10'b01_01_00_00_00 :
          (k > 6)  ? 10'b01_00_00_00_00 : 10'b0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_async_a", oa(), 10'b0);
    chk("mid_async_b", ob(), 10'b0);
    step();
    bin = 2'b10;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("mid_post%0d", k), oa(), 10'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
